// File: rtl/pdm_decoder_pkg.sv
// Shared constants for the PDM link: default amplitude width and window sizing.
// The encoder and decoder both take their window length from window_size().
package pdm_decoder_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  function automatic int window_size(input int data_bits);
    return 1 << data_bits;
  endfunction

endpackage

// File: rtl/pdm_decoder_bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both stages reset to 0. Reusable for any asynchronous control input in the synth.
module bit_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so both stages shift on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[0], i_async};
  end

  assign o_sync = r_sync[1];

endmodule

// File: rtl/pdm_decoder.sv
// Boxcar PDM decimator: counts ones over 2**DATA_BITS input samples and emits
// one saturated amplitude per window, with one-cycle valid/clipped strobes.
module pdm_decoder
  import pdm_decoder_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int DIVIDER   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pdm_in,
  output logic [DATA_BITS-1:0] amplitude,
  output logic                 valid,
  output logic                 clipped
);

  localparam int                 PW         = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(DIVIDER - 1);
  localparam logic [DATA_BITS:0] FULL_SCALE = (DATA_BITS + 1)'(window_size(DATA_BITS));

  logic                 w_pdm_s;
  logic                 w_sample_en;
  logic                 w_window_end;
  logic                 w_clip;
  logic [DATA_BITS:0]   w_total;
  logic [PW-1:0]        r_presc;
  logic [DATA_BITS-1:0] r_window;
  logic [DATA_BITS:0]   r_ones;
  logic [DATA_BITS-1:0] r_amplitude;
  logic                 r_valid;
  logic                 r_clipped;

  bit_synchronizer u_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (pdm_in),
    .o_sync  (w_pdm_s)
  );

  assign w_sample_en  = (r_presc == PRESC_LAST);
  assign w_window_end = w_sample_en && (r_window == '1);
  // The bit arriving on the last sample belongs to the closing window.
  assign w_total      = r_ones + {{DATA_BITS{1'b0}}, w_pdm_s};
  assign w_clip       = (w_total == FULL_SCALE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_sample_en) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_window <= '0;
      r_ones   <= '0;
    end else if (w_sample_en) begin
      r_window <= r_window + DATA_BITS'(1);
      r_ones   <= w_window_end ? '0 : w_total;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_amplitude <= '0;
      r_valid     <= 1'b0;
      r_clipped   <= 1'b0;
    end else begin
      r_valid   <= w_window_end;
      r_clipped <= w_window_end && w_clip;
      if (w_window_end) begin
        r_amplitude <= w_clip ? '1 : w_total[DATA_BITS-1:0];
      end
    end
  end

  assign amplitude = r_amplitude;
  assign valid     = r_valid;
  assign clipped   = r_clipped;

endmodule

// File: tb/tb_pdm_decoder.sv
// Self-checking bench for pdm_decoder: an every-cycle window-sum model for a
// DIVIDER=1 and a DIVIDER=4 instance, plus directed literal expectations.
module tb_pdm_decoder;

  localparam int DB  = 8;
  localparam int WIN = 1 << DB;

  typedef enum logic [1:0] {M_CONST, M_TOGGLE, M_ENC} drive_mode_t;

  typedef struct packed {
    int unsigned edges;
    int unsigned samples;
    int unsigned ones;
    int unsigned amp;
    logic        in_one_ago;
    logic        in_two_ago;
    logic        valid;
    logic        clip;
  } model_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pdm1  = 1'b0;
  logic          pdm4  = 1'b0;
  logic [DB-1:0] amp1, amp4;
  logic          valid1, valid4, clip1, clip4;

  drive_mode_t   mode    = M_CONST;
  logic          level   = 1'b0;
  logic [DB-1:0] enc_amp = '0;
  logic [DB-1:0] enc_acc = '0;

  model_t m1, m4;
  int total = 0;
  int bad   = 0;

  pdm_decoder #(.DATA_BITS(DB), .DIVIDER(1)) dut1 (
    .clock(clock), .reset(reset), .pdm_in(pdm1),
    .amplitude(amp1), .valid(valid1), .clipped(clip1)
  );

  pdm_decoder #(.DATA_BITS(DB), .DIVIDER(4)) dut4 (
    .clock(clock), .reset(reset), .pdm_in(pdm4),
    .amplitude(amp4), .valid(valid4), .clipped(clip4)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    total++;
    if (actual < lo || actual > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Behavioural model: the sample taken at clock edge n is the input seen at edge n-2
  // (zero before reset release); each window of WIN samples yields min(sum, WIN-1).
  function automatic model_t model_step(input model_t s, input logic in_bit, input int div);
    model_t r = s;
    logic   delayed;
    r.edges      = s.edges + 1;
    delayed      = s.in_two_ago;
    r.in_two_ago = s.in_one_ago;
    r.in_one_ago = in_bit;
    r.valid      = 1'b0;
    r.clip       = 1'b0;
    if (r.edges % div == 0) begin
      r.samples = s.samples + 1;
      r.ones    = s.ones + (delayed ? 1 : 0);
      if (r.samples % WIN == 0) begin
        r.valid = 1'b1;
        r.clip  = (r.ones == WIN);
        r.amp   = r.clip ? WIN - 1 : r.ones;
        r.ones  = 0;
      end
    end
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m1 <= '0;
      m4 <= '0;
    end else begin
      m1 <= model_step(m1, pdm1, 1);
      m4 <= model_step(m4, pdm4, 4);
    end
  end

  initial forever begin
    @(negedge clock);
    #1;
    if (!reset) begin
      check("m1_valid", valid1, m1.valid);
      check("m1_amp",   amp1,   m1.amp);
      check("m1_clip",  clip1,  m1.clip);
      check("m4_valid", valid4, m4.valid);
      check("m4_amp",   amp4,   m4.amp);
      check("m4_clip",  clip4,  m4.clip);
    end
  end

  // Input drivers change only on the falling edge, away from DUT sampling.
  initial forever begin
    logic [DB:0] sum9;
    @(negedge clock);
    case (mode)
      M_CONST:  pdm1 = level;
      M_TOGGLE: pdm1 = ~pdm1;
      M_ENC: begin
        sum9    = {1'b0, enc_acc} + {1'b0, enc_amp};
        enc_acc = sum9[DB-1:0];
        pdm1    = sum9[DB];
      end
      default:  pdm1 = 1'b0;
    endcase
  end

  initial begin
    int unsigned ph = 0;
    forever begin
      @(negedge clock);
      pdm4 = (ph % 4 == 0);
      ph++;
    end
  end

  task automatic wait_valid(input int which, input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (!(which == 1 ? valid4 : valid1) && cycles < limit);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int c;

    // Reset state
    @(negedge clock);
    #1;
    check("rst_amp1",   amp1,   0);
    check("rst_valid1", valid1, 0);
    check("rst_clip1",  clip1,  0);
    check("rst_amp4",   amp4,   0);
    check("rst_valid4", valid4, 0);
    @(negedge clock);
    reset = 1'b0;

    // Constant zero: three windows, each 256 clocks apart
    for (int w = 0; w < 3; w++) begin
      wait_valid(0, 600, c);
      check("t1_period", c, WIN);
      check("t1_amp",    amp1,  0);
      check("t1_clip",   clip1, 0);
    end

    // Constant one from reset: first window loses the two synchronizer zeros
    level = 1'b1;
    do_reset();
    wait_valid(0, 600, c);
    check("t2_first_time", c, WIN);
    check("t2_first_amp",  amp1,  254);
    check("t2_first_clip", clip1, 0);
    wait_valid(0, 600, c);
    check("t2_full_amp",   amp1,  255);
    check("t2_full_clip",  clip1, 1);

    // Alternating input: exactly half of every full window
    mode = M_TOGGLE;
    wait_valid(0, 600, c);
    for (int w = 0; w < 2; w++) begin
      wait_valid(0, 600, c);
      check("t3_period", c, WIN);
      check("t3_amp",    amp1,  128);
      check("t3_clip",   clip1, 0);
    end

    // Loopback with a first-order sigma-delta encoder
    enc_amp = 8'd64;
    mode    = M_ENC;
    repeat (2) wait_valid(0, 600, c);
    wait_valid(0, 600, c);
    check_range("t4_amp64", amp1, 63, 65);
    enc_amp = 8'd200;
    repeat (2) wait_valid(0, 600, c);
    wait_valid(0, 600, c);
    check_range("t4_amp200", amp1, 199, 201);

    // Reset 100 clocks into a window
    mode = M_TOGGLE;
    wait_valid(0, 600, c);
    repeat (100) @(negedge clock);
    reset = 1'b1;
    #1;
    check("t5_amp",   amp1,   0);
    check("t5_valid", valid1, 0);
    check("t5_clip",  clip1,  0);
    @(negedge clock);
    reset = 1'b0;
    wait_valid(0, 600, c);
    check("t5_restart", c, WIN);

    // DIVIDER=4 instance: one-in-four pulses land either all on or all off the sample phase
    do_reset();
    wait_valid(1, 2000, c);
    check("t6_first_time", c, 4 * WIN);
    check("t6_amp_legal", (amp4 == 0 || amp4 == 255) ? 1 : 0, 1);
    wait_valid(1, 2000, c);
    check("t6_period", c, 4 * WIN);
    check("t6_amp_legal2", (amp4 == 0 || amp4 == 255) ? 1 : 0, 1);

    repeat (4) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
